// File: rtl/multi_digit_updown_counter.sv
// Cascaded modulo-MOD up/down counter with NUM_DIGITS 4-bit digits.
// Supports parallel load, wrap or saturate at the range ends, and a sticky overflow flag.
module multi_digit_updown_counter #(
  parameter int NUM_DIGITS = 4,
  parameter int MOD        = 10
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clk_en,
  input  logic                    inc,
  input  logic                    dec,
  input  logic                    clr,
  input  logic                    ld,
  input  logic [4*NUM_DIGITS-1:0] ld_val,
  input  logic                    sat_mode,
  output logic [4*NUM_DIGITS-1:0] cnt_out,
  output logic                    co,
  output logic                    bo,
  output logic                    ovf
);

  localparam int         W        = 4 * NUM_DIGITS;
  localparam logic [3:0] TOP      = 4'(MOD - 1);
  localparam logic [4:0] MOD_WIDE = 5'(MOD);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;
  logic [W-1:0] up_val;
  logic [W-1:0] dn_val;
  logic [W-1:0] ld_clamped;
  logic         ovf_q;
  logic         ovf_d;
  logic         carry;
  logic         borrow;
  logic         all_top;
  logic         all_zero;
  logic         count_en;

  always_comb begin
    all_top  = 1'b1;
    all_zero = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (count_q[4*i +: 4] != TOP) all_top = 1'b0;
      if (count_q[4*i +: 4] != 4'd0) all_zero = 1'b0;
    end
  end

  // Single-cycle ripple chains; at the terminal values they naturally produce the wrap result.
  always_comb begin
    up_val = count_q;
    dn_val = count_q;
    carry  = 1'b1;
    borrow = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (carry) begin
        if (count_q[4*i +: 4] == TOP) begin
          up_val[4*i +: 4] = 4'd0;
        end else begin
          up_val[4*i +: 4] = count_q[4*i +: 4] + 4'd1;
          carry            = 1'b0;
        end
      end
      if (borrow) begin
        if (count_q[4*i +: 4] == 4'd0) begin
          dn_val[4*i +: 4] = TOP;
        end else begin
          dn_val[4*i +: 4] = count_q[4*i +: 4] - 4'd1;
          borrow           = 1'b0;
        end
      end
    end
  end

  always_comb begin
    ld_clamped = ld_val;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if ({1'b0, ld_val[4*i +: 4]} >= MOD_WIDE) ld_clamped[4*i +: 4] = TOP;
    end
  end

  assign count_en = clk_en & (inc ^ dec);

  always_comb begin
    count_d = count_q;
    ovf_d   = ovf_q;
    if (clr) begin
      count_d = '0;
      ovf_d   = 1'b0;
    end else if (ld) begin
      count_d = ld_clamped;
    end else if (count_en) begin
      if (inc) begin
        if (all_top) begin
          ovf_d   = 1'b1;
          count_d = sat_mode ? count_q : up_val;
        end else begin
          count_d = up_val;
        end
      end else begin
        if (all_zero) begin
          ovf_d   = 1'b1;
          count_d = sat_mode ? count_q : dn_val;
        end else begin
          count_d = dn_val;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  assign cnt_out = count_q;
  assign ovf     = ovf_q;
  assign co      = all_top;
  assign bo      = all_zero;

endmodule

// File: tb/tb_multi_digit_updown_counter.sv
// Directed bench: a 2-digit decade counter and a 3-digit modulo-6 counter,
// each checked against hand-computed values.
module tb_multi_digit_updown_counter;

  logic        clk;
  logic        rst, clk_en, inc, dec, clr, ld, sat_mode;
  logic [7:0]  ld_val;
  logic [7:0]  cnt_out;
  logic        co, bo, ovf;

  logic        rst2, clk_en2, inc2;
  logic [11:0] cnt_out2;
  logic        co2, bo2, ovf2;

  int assertCount = 0;
  int failCount   = 0;

  multi_digit_updown_counter #(.NUM_DIGITS(2), .MOD(10)) dut (
    .clk(clk), .rst(rst), .clk_en(clk_en), .inc(inc), .dec(dec),
    .clr(clr), .ld(ld), .ld_val(ld_val), .sat_mode(sat_mode),
    .cnt_out(cnt_out), .co(co), .bo(bo), .ovf(ovf)
  );

  multi_digit_updown_counter #(.NUM_DIGITS(3), .MOD(6)) dut6 (
    .clk(clk), .rst(rst2), .clk_en(clk_en2), .inc(inc2), .dec(1'b0),
    .clr(1'b0), .ld(1'b0), .ld_val(12'h000), .sat_mode(1'b0),
    .cnt_out(cnt_out2), .co(co2), .bo(bo2), .ovf(ovf2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Advance n clock edges; inputs change and outputs are sampled 1 time unit after each edge.
  task automatic applyStimulus(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst = 1'b0; clk_en = 1'b0; inc = 1'b0; dec = 1'b0;
    clr = 1'b0; ld = 1'b0; sat_mode = 1'b0; ld_val = 8'h00;
    rst2 = 1'b0; clk_en2 = 1'b0; inc2 = 1'b0;

    applyStimulus(3);
    checkOutput("reset_cnt", 32'(cnt_out), 32'h00);
    checkOutput("reset_ovf", 32'(ovf), 32'h0);
    checkOutput("reset_co", 32'(co), 32'h0);
    checkOutput("reset_bo", 32'(bo), 32'h1);
    rst = 1'b1;

    // Full-range count up, then wrap
    clk_en = 1'b1; inc = 1'b1;
    applyStimulus(1);
    checkOutput("first_inc", 32'(cnt_out), 32'h01);
    applyStimulus(98);
    checkOutput("count99_cnt", 32'(cnt_out), 32'h99);
    checkOutput("count99_co", 32'(co), 32'h1);
    checkOutput("count99_ovf", 32'(ovf), 32'h0);
    applyStimulus(1);
    checkOutput("wrap_up_cnt", 32'(cnt_out), 32'h00);
    checkOutput("wrap_up_ovf", 32'(ovf), 32'h1);
    checkOutput("wrap_up_bo", 32'(bo), 32'h1);

    // Carry and borrow between digits
    inc = 1'b0; clk_en = 1'b0; clr = 1'b1;
    applyStimulus(1);
    checkOutput("clr_ovf", 32'(ovf), 32'h0);
    clr = 1'b0; ld = 1'b1; ld_val = 8'h19;
    applyStimulus(1);
    checkOutput("load19", 32'(cnt_out), 32'h19);
    ld = 1'b0; clk_en = 1'b1; inc = 1'b1;
    applyStimulus(1);
    checkOutput("carry_20", 32'(cnt_out), 32'h20);
    inc = 1'b0; dec = 1'b1;
    applyStimulus(1);
    checkOutput("borrow_19", 32'(cnt_out), 32'h19);
    checkOutput("borrow_ovf", 32'(ovf), 32'h0);

    // Wrap down from zero
    dec = 1'b0; ld = 1'b1; ld_val = 8'h00;
    applyStimulus(1);
    ld = 1'b0; dec = 1'b1;
    applyStimulus(1);
    checkOutput("wrap_dn_cnt", 32'(cnt_out), 32'h99);
    checkOutput("wrap_dn_ovf", 32'(ovf), 32'h1);

    // Saturation at both ends
    dec = 1'b0; clr = 1'b1;
    applyStimulus(1);
    clr = 1'b0; sat_mode = 1'b1; ld = 1'b1; ld_val = 8'h00;
    applyStimulus(1);
    ld = 1'b0; dec = 1'b1;
    applyStimulus(1);
    checkOutput("sat_dn_cnt", 32'(cnt_out), 32'h00);
    checkOutput("sat_dn_ovf", 32'(ovf), 32'h1);
    dec = 1'b0; clr = 1'b1;
    applyStimulus(1);
    clr = 1'b0; ld = 1'b1; ld_val = 8'h99;
    applyStimulus(1);
    ld = 1'b0; inc = 1'b1;
    applyStimulus(1);
    checkOutput("sat_up_cnt", 32'(cnt_out), 32'h99);
    checkOutput("sat_up_ovf", 32'(ovf), 32'h1);
    sat_mode = 1'b0;

    // Priority: clear over load over count, and load clamping
    clr = 1'b1; ld = 1'b1; ld_val = 8'h55;
    applyStimulus(1);
    checkOutput("prio_clr_cnt", 32'(cnt_out), 32'h00);
    checkOutput("prio_clr_ovf", 32'(ovf), 32'h0);
    clr = 1'b0; ld_val = 8'hAF;
    applyStimulus(1);
    checkOutput("clamp_cnt", 32'(cnt_out), 32'h99);
    checkOutput("clamp_ovf", 32'(ovf), 32'h0);

    // Hold cases
    ld_val = 8'h42;
    applyStimulus(1);
    ld = 1'b0; dec = 1'b1;
    applyStimulus(1);
    checkOutput("hold_incdec", 32'(cnt_out), 32'h42);
    dec = 1'b0; clk_en = 1'b0;
    applyStimulus(20);
    checkOutput("hold_noen", 32'(cnt_out), 32'h42);

    // Asynchronous reset mid-count with ovf already set
    clk_en = 1'b1; ld = 1'b1; ld_val = 8'h99;
    applyStimulus(1);
    ld = 1'b0;
    applyStimulus(58);
    checkOutput("pre_rst_cnt", 32'(cnt_out), 32'h57);
    checkOutput("pre_rst_ovf", 32'(ovf), 32'h1);
    inc = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    checkOutput("async_rst_cnt", 32'(cnt_out), 32'h00);
    checkOutput("async_rst_ovf", 32'(ovf), 32'h0);
    checkOutput("async_rst_bo", 32'(bo), 32'h1);
    applyStimulus(1);
    rst = 1'b1; inc = 1'b1;
    applyStimulus(1);
    checkOutput("post_rst_inc", 32'(cnt_out), 32'h01);
    inc = 1'b0; clk_en = 1'b0;

    // Three-digit modulo-6 counter
    rst2 = 1'b1; clk_en2 = 1'b1; inc2 = 1'b1;
    applyStimulus(6);
    checkOutput("mod6_carry", 32'(cnt_out2), 32'h010);
    applyStimulus(209);
    checkOutput("mod6_555_cnt", 32'(cnt_out2), 32'h555);
    checkOutput("mod6_555_co", 32'(co2), 32'h1);
    checkOutput("mod6_555_ovf", 32'(ovf2), 32'h0);
    applyStimulus(1);
    checkOutput("mod6_wrap_cnt", 32'(cnt_out2), 32'h000);
    checkOutput("mod6_wrap_ovf", 32'(ovf2), 32'h1);
    checkOutput("mod6_wrap_bo", 32'(bo2), 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/multi_digit_updown_counter.md
Name: multi_digit_updown_counter

Overview:
Parametrised cascaded modulo-MOD up/down counter. Generalises the single-digit decade counter to NUM_DIGITS digits with internal ripple-carry and ripple-borrow between digits. Adds down-counting, parallel load, wrap or saturate mode, and a sticky overflow flag. Used as the event or time counter feeding 7-segment display drivers in the lab designs.

Parameters:
NUM_DIGITS, 4, number of cascaded digits (1..8); digit 0 is least significant.
MOD, 10, modulus of every digit (2..16); each digit counts 0..MOD-1 and is stored in 4 bits.

Ports:
clk  input  1  system clock, rising-edge active.
rst  input  1  asynchronous, active-low reset.
clk_en  input  1  count-enable tick; counting happens only when clk_en=1.
inc  input  1  count up by one on an enabled cycle.
dec  input  1  count down by one on an enabled cycle.
clr  input  1  synchronous clear of count and overflow flag.
ld  input  1  synchronous parallel load.
ld_val  input  4*NUM_DIGITS  load value, one 4-bit digit per nibble; digit 0 in [3:0].
sat_mode  input  1  0 = wrap at the ends of the range, 1 = saturate at the ends.
cnt_out  output  4*NUM_DIGITS  registered count, one digit per nibble.
co  output  1  combinational terminal-high flag: every digit equals MOD-1.
bo  output  1  combinational terminal-low flag: every digit equals 0.
ovf  output  1  registered sticky flag: a wrap or saturation event has occurred.

Behaviour:
- rst=0, asynchronous: cnt_out=0 and ovf=0. Consequently co=0 and bo=1.
- Synchronous priority on each rising clk edge: clr > ld > count > hold.
- clr=1: cnt_out<=0 and ovf<=0. clk_en, inc, dec and ld are ignored.
- ld=1 (clr=0): each digit <= its ld_val nibble. Any nibble >= MOD is clamped to MOD-1. ovf is unchanged. clk_en is not required.
- Count condition: clk_en=1 and exactly one of inc/dec is 1. inc=dec=1 or inc=dec=0 means hold.
- Up count:
  - Digit 0 increments.
  - A digit at MOD-1 that is incremented goes to 0 and passes a carry to the next digit, in the same cycle.
  - If co=1 before the edge:
    - sat_mode=0: all digits go to 0, ovf<=1.
    - sat_mode=1: count holds at all MOD-1, ovf<=1.
- Down count:
  - Digit 0 decrements.
  - A digit at 0 that is decremented goes to MOD-1 and passes a borrow to the next digit.
  - If bo=1 before the edge:
    - sat_mode=0: all digits go to MOD-1, ovf<=1.
    - sat_mode=1: count holds at 0, ovf<=1.
- Latency: one cycle from the enabled edge to cnt_out. co and bo follow cnt_out combinationally with no extra delay.
- Carry/borrow chain is combinational within a cycle. There is no multi-cycle ripple; all digits update on the same edge.
- ovf is set only by the terminal events above and stays 1 until clr or rst.
- sat_mode may change on any cycle; it takes effect on the next counting edge.
- A digit value >= MOD is never produced by any path.
- NUM_DIGITS=1, MOD=10 with dec=0, ld=0 and sat_mode=0 reproduces the plain decade-counter behaviour, co included.
- rst asserted mid-count clears immediately, without waiting for clk. Counting resumes on the first enabled edge after rst returns to 1.

Test Plan:
1. Parameters NUM_DIGITS=2, MOD=10. Release rst, hold inc=1 and clk_en=1 for 99 edges -> cnt_out=8'h99, co=1, ovf=0. One more edge -> cnt_out=8'h00, ovf=1, bo=1.
2. Carry: ld_val=8'h19, ld=1 for one edge, then one enabled inc -> cnt_out=8'h20. Enabled dec from 8'h20 -> 8'h19.
3. Saturate: sat_mode=1, load 8'h00, enabled dec -> cnt_out stays 8'h00, ovf=1. Load 8'h99, enabled inc -> stays 8'h99.
4. Priority and clamp: clr=1 with ld=1 and inc=1 -> cnt_out=0, ovf=0. Next, ld_val=8'hAF with ld=1 and inc=1 -> cnt_out=8'h99 (load wins, nibbles clamped).
5. Hold cases: inc=dec=1 with clk_en=1 -> no change. inc=1 with clk_en=0 for 20 edges -> no change.
6. Async reset: count to 8'h57, pull rst low between clock edges -> cnt_out=0, ovf=0, bo=1 immediately. Release rst, one enabled inc -> 8'h01. Repeat with NUM_DIGITS=3, MOD=6: 215 increments from 0 -> co=1 (digits 5,5,5).
